// File: rtl/ext_mem_ctrl.sv
// Single-outstanding word server between a DMA master port and a synchronous single-port SRAM.
// Latency: valid_extmem pulses RD_LAT (read) / WR_LAT (write) cycles after the request is accepted.
// Backpressure: none; one transaction at a time, inputs sampled only in IDLE (busy=1 while in flight).
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   request_extmem, write_extmem, addr_extmem, w_data    DMA request side (held by requester)
//   valid_extmem, data_extmem                            completion pulse and registered read data
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata       SRAM side, read data one cycle after mem_en
//   cnt_clr, busy, err_oob, rd_cnt, wr_cnt               status and saturating transaction counters
module ext_mem_ctrl #(
  parameter int          DATA_W    = 32,
  parameter int          MEM_DEPTH = 65536,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          RD_LAT    = 4,
  parameter int          WR_LAT    = 2,
  localparam int         AW        = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request_extmem,
  input  logic              write_extmem,
  input  logic [31:0]       addr_extmem,
  input  logic [DATA_W-1:0] w_data,
  output logic              valid_extmem,
  output logic [DATA_W-1:0] data_extmem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              cnt_clr,
  output logic              busy,
  output logic              err_oob,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [DATA_W-1:0] OOB_WORD = DATA_W'(32'hDEADBEEF);

  logic [1:0]        state;
  logic              wr_q;
  logic              oob_q;
  logic [AW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        lat_cnt;
  logic [DATA_W-1:0] hold_q;
  logic              hold_vld;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic [31:0]       rd_cnt_q;
  logic [31:0]       wr_cnt_q;

  logic [31:0]       off_in;
  logic              oob_in;
  logic              issue;
  logic              resp_now;
  logic [DATA_W-1:0] rsp_word;

  // Offset is computed full-width so the range test cannot wrap.
  always_comb begin
    off_in = addr_extmem - BASE_ADDR;
    oob_in = (addr_extmem < BASE_ADDR) || (off_in >= 32'(MEM_DEPTH));
  end

  always_comb begin
    issue    = (state == ISSUE);
    // A latency of 1 completes in the ISSUE cycle itself (writes only).
    resp_now = (state == RESP) || (issue && (lat_cnt == 4'd0));
    // With RD_LAT=2 there is no WAIT cycle, so the SRAM output is forwarded directly.
    rsp_word = oob_q ? OOB_WORD : (hold_vld ? hold_q : mem_rdata);

    mem_en       = issue && !oob_q;
    mem_we       = mem_en && wr_q;
    mem_addr     = mem_en ? idx_q : '0;
    mem_wdata    = mem_we ? wdata_q : '0;
    valid_extmem = resp_now;
    data_extmem  = (resp_now && !wr_q) ? rsp_word : data_q;
    busy         = (state != IDLE);
    err_oob      = err_q;
    rd_cnt       = rd_cnt_q;
    wr_cnt       = wr_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wr_q     <= 1'b0;
      oob_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      lat_cnt  <= 4'd0;
      hold_q   <= '0;
      hold_vld <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          hold_vld <= 1'b0;
          if (request_extmem) begin
            wr_q    <= write_extmem;
            oob_q   <= oob_in;
            idx_q   <= off_in[AW-1:0];
            wdata_q <= w_data;
            lat_cnt <= write_extmem ? 4'(WR_LAT - 1) : 4'(RD_LAT - 1);
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (oob_q) err_q <= 1'b1;
          if (lat_cnt == 4'd0) begin
            state <= IDLE;
          end else if (lat_cnt == 4'd1) begin
            state <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // SRAM data is only valid in the first cycle after the access.
          if (!wr_q && !hold_vld) begin
            hold_q   <= mem_rdata;
            hold_vld <= 1'b1;
          end
          if (lat_cnt == 4'd1) state <= RESP;
          else lat_cnt <= lat_cnt - 4'd1;
        end
        RESP: begin
          if (!wr_q) data_q <= rsp_word;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (cnt_clr) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (resp_now) begin
      if (!wr_q && (rd_cnt_q != 32'hFFFF_FFFF)) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (wr_q && (wr_cnt_q != 32'hFFFF_FFFF)) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

endmodule
